// File: rtl/universal_register_pkg.sv
// Shared mode encoding for the universal register family.
// Latency: n/a (constants only).
// Backpressure: n/a; holding is expressed through the en input of the register.
package universal_register_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_INV  = 3'b111;

endpackage

// File: rtl/universal_register_cell.sv
// One bit of the universal register: 8:1 next-state mux feeding an async-reset flop.
// Latency: one clk edge from sampled inputs to q; reset acts immediately.
// Backpressure: none; en=0 simply holds the stored bit.
module universal_register_cell
  import universal_register_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              d,
  input  logic              left,     // bit that rotates in on ROR (upper neighbour or wrap)
  input  logic              right,    // bit that rotates in on ROL (lower neighbour or wrap)
  input  logic              sin_shl,  // bit that shifts in on SHL (lower neighbour or sin_r)
  input  logic              sin_shr,  // bit that shifts in on SHR (upper neighbour or sin_l)
  output logic              q
);

  logic q_nxt;

  // Select the next stored bit; unselected sources never reach q, so X on them is harmless.
  always_comb begin
    q_nxt = q;
    if (en) begin
      case (mode)
        MODE_HOLD: q_nxt = q;
        MODE_LOAD: q_nxt = d;
        MODE_SHL:  q_nxt = sin_shl;
        MODE_SHR:  q_nxt = sin_shr;
        MODE_ROL:  q_nxt = right;
        MODE_ROR:  q_nxt = left;
        MODE_CLR:  q_nxt = 1'b0;
        MODE_INV:  q_nxt = ~q;
        default:   q_nxt = q;
      endcase
    end
  end

  // Storage flop; asynchronous reset discards whatever operation is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= RST_VAL;
    else     q <= q_nxt;
  end

endmodule

// File: rtl/universal_register.sv
// WIDTH-bit register with hold/load/shift/rotate/clear/invert modes and serial taps.
// Latency: one clk edge to q; q_n, sout_l, sout_r are combinational from q.
// Backpressure: none; en=0 freezes the register regardless of mode.
module universal_register
  import universal_register_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_r,
  input  logic              sin_l,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  q_n,
  output logic              sout_l,
  output logic              sout_r
);

  // Per-bit neighbour sources; edge bits take the serial inputs or the wrap-around bit.
  logic [WIDTH-1:0] rot_left;
  logic [WIDTH-1:0] rot_right;
  logic [WIDTH-1:0] shl_src;
  logic [WIDTH-1:0] shr_src;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lsb
      assign rot_right[i] = q[WIDTH-1];
      assign shl_src[i]   = sin_r;
    end else begin : g_lo_nb
      assign rot_right[i] = q[i-1];
      assign shl_src[i]   = q[i-1];
    end

    if (i == WIDTH-1) begin : g_msb
      assign rot_left[i] = q[0];
      assign shr_src[i]  = sin_l;
    end else begin : g_hi_nb
      assign rot_left[i] = q[i+1];
      assign shr_src[i]  = q[i+1];
    end

    universal_register_cell #(
      .RST_VAL (RESET_VAL[i])
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (mode),
      .d       (d[i]),
      .left    (rot_left[i]),
      .right   (rot_right[i]),
      .sin_shl (shl_src[i]),
      .sin_shr (shr_src[i]),
      .q       (q[i])
    );
  end

  // Complement and chaining taps derived directly from the stored value.
  always_comb begin
    q_n    = ~q;
    sout_l = q[WIDTH-1];
    sout_r = q[0];
  end

endmodule

// File: tb/tb_universal_register.sv
// Scoreboarded bench for universal_register: an 8-bit instance with a non-zero reset value and a 1-bit instance.
// Expected values are pushed when an operation is driven and compared one edge later.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_universal_register;
  import universal_register_pkg::*;

  logic clk = 1'b0;
  logic rst;

  logic       en8, sr8, sl8;
  logic [2:0] mode8;
  logic [7:0] d8, q8, qn8;
  logic       soutl8, soutr8;

  logic       en1, sr1, sl1, d1;
  logic [2:0] mode1;
  logic [0:0] q1, qn1;
  logic       soutl1, soutr1;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] sb8[$];
  logic       sb1[$];

  always #5 clk = ~clk;

  universal_register #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
    .clk(clk), .rst(rst), .en(en8), .mode(mode8), .d(d8), .sin_r(sr8), .sin_l(sl8),
    .q(q8), .q_n(qn8), .sout_l(soutl8), .sout_r(soutr8)
  );

  universal_register #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .mode(mode1), .d(d1), .sin_r(sr1), .sin_l(sl1),
    .q(q1), .q_n(qn1), .sout_l(soutl1), .sout_r(soutr1)
  );

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] e);
    check_val({tag, ".q"},      {56'd0, q8},     {56'd0, e});
    check_val({tag, ".q_n"},    {56'd0, qn8},    {56'd0, ~e});
    check_val({tag, ".sout_l"}, {63'd0, soutl8}, {63'd0, e[7]});
    check_val({tag, ".sout_r"}, {63'd0, soutr8}, {63'd0, e[0]});
  endtask

  // Drive one operation on the 8-bit instance and score the result after the next edge.
  task automatic op8(input string tag, input logic e, input logic [2:0] m, input logic [7:0] dv,
                     input logic sr, input logic sl, input logic [7:0] expv);
    logic [7:0] want;
    @(negedge clk);
    en8 = e; mode8 = m; d8 = dv; sr8 = sr; sl8 = sl;
    sb8.push_back(expv);
    @(posedge clk);
    #1;
    if (sb8.size() == 0) begin
      check_val({tag, ".sb_empty"}, 64'd0, 64'd1);
    end else begin
      want = sb8.pop_front();
      check8(tag, want);
    end
  endtask

  task automatic op1(input string tag, input logic e, input logic [2:0] m, input logic dv,
                     input logic sr, input logic sl, input logic expv);
    logic want;
    @(negedge clk);
    en1 = e; mode1 = m; d1 = dv; sr1 = sr; sl1 = sl;
    sb1.push_back(expv);
    @(posedge clk);
    #1;
    if (sb1.size() == 0) begin
      check_val({tag, ".sb_empty"}, 64'd0, 64'd1);
    end else begin
      want = sb1.pop_front();
      check_val({tag, ".q"},      {63'd0, q1[0]},  {63'd0, want});
      check_val({tag, ".q_n"},    {63'd0, qn1[0]}, {63'd0, ~want});
      check_val({tag, ".sout_l"}, {63'd0, soutl1}, {63'd0, want});
      check_val({tag, ".sout_r"}, {63'd0, soutr1}, {63'd0, want});
    end
  endtask

  // Whole-vector reference for the random phase.
  function automatic logic [7:0] model8(input logic [7:0] cur, input logic e, input logic [2:0] m,
                                        input logic [7:0] dv, input logic sr, input logic sl);
    if (!e) return cur;
    case (m)
      MODE_LOAD: return dv;
      MODE_SHL:  return (cur << 1) | {7'd0, sr};
      MODE_SHR:  return (cur >> 1) | {sl, 7'd0};
      MODE_ROL:  return (cur << 1) | (cur >> 7);
      MODE_ROR:  return (cur >> 1) | (cur << 7);
      MODE_CLR:  return 8'h00;
      MODE_INV:  return cur ^ 8'hFF;
      default:   return cur;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [7:0] v;
    logic [7:0] mq;
    logic       re;
    logic [2:0] rm;
    logic [7:0] rd;
    logic       rsr, rsl;

    rst = 1'b1;
    en8 = 1'b0; mode8 = MODE_HOLD; d8 = 8'h00; sr8 = 1'b0; sl8 = 1'b0;
    en1 = 1'b0; mode1 = MODE_HOLD; d1 = 1'b0; sr1 = 1'b0; sl1 = 1'b0;

    // Reset is visible before any clock edge.
    #2;
    check8("rst_init", 8'hA5);
    check_val("rst_init.q1", {63'd0, q1[0]}, 64'd0);
    #10;
    rst = 1'b0;

    // Load and enable.
    op8("load_3c", 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b0, 8'h3C);
    for (int i = 0; i < 3; i++) op8("en0_hold", 1'b0, MODE_LOAD, 8'hFF, 1'b1, 1'b1, 8'h3C);

    // Async reset mid-cycle discards a pending LOAD.
    @(negedge clk);
    en8 = 1'b1; mode8 = MODE_LOAD; d8 = 8'h11;
    #2;
    rst = 1'b1;
    #1;
    check8("arst_mid", 8'hA5);
    @(posedge clk);
    #2;
    rst = 1'b0;
    en8 = 1'b0;
    #1;
    check8("arst_discard", 8'hA5);

    // Shifts.
    op8("load_81", 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81);
    op8("shl", 1'b1, MODE_SHL, 8'h00, 1'b1, 1'b0, 8'h03);
    op8("shr", 1'b1, MODE_SHR, 8'h00, 1'b0, 1'b0, 8'h01);

    // Rotates.
    op8("load_81b", 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'h81);
    op8("rol", 1'b1, MODE_ROL, 8'hxx, 1'bx, 1'bx, 8'h03);
    op8("ror1", 1'b1, MODE_ROR, 8'hxx, 1'bx, 1'bx, 8'h81);
    op8("ror2", 1'b1, MODE_ROR, 8'hxx, 1'bx, 1'bx, 8'hC0);
    op8("load_5a", 1'b1, MODE_LOAD, 8'h5A, 1'b0, 1'b0, 8'h5A);
    v = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      v = {v[6:0], v[7]};
      op8("rol8", 1'b1, MODE_ROL, 8'h00, 1'b0, 1'b0, v);
    end
    check_val("rol8_back", {56'd0, q8}, 64'h5A);

    // Invert, clear, hold with undriven data.
    op8("inv1", 1'b1, MODE_INV, 8'h00, 1'b0, 1'b0, 8'hA5);
    op8("inv2", 1'b1, MODE_INV, 8'h00, 1'b0, 1'b0, 8'h5A);
    op8("clr", 1'b1, MODE_CLR, 8'hFF, 1'b1, 1'b1, 8'h00);
    op8("hold_x", 1'b1, MODE_HOLD, 8'hxx, 1'bx, 1'bx, 8'h00);
    check_val("hold_x.noX", {63'd0, $isunknown(q8)}, 64'd0);

    // Random operations against the reference model.
    mq = q8;
    for (int i = 0; i < 60; i++) begin
      re  = ($urandom_range(0, 7) != 0);
      rm  = 3'($urandom_range(0, 7));
      rd  = 8'($urandom);
      rsr = 1'($urandom);
      rsl = 1'($urandom);
      mq  = model8(mq, re, rm, rd, rsr, rsl);
      op8("rand", re, rm, rd, rsr, rsl, mq);
    end

    // One-bit instance boundary behaviour.
    op1("w1_shl", 1'b1, MODE_SHL, 1'b0, 1'b1, 1'b0, 1'b1);
    op1("w1_rol", 1'b1, MODE_ROL, 1'bx, 1'bx, 1'bx, 1'b1);
    op1("w1_ror", 1'b1, MODE_ROR, 1'bx, 1'bx, 1'bx, 1'b1);
    op1("w1_inv", 1'b1, MODE_INV, 1'b1, 1'b1, 1'b1, 1'b0);
    op1("w1_shr", 1'b1, MODE_SHR, 1'b0, 1'b0, 1'b1, 1'b1);
    op1("w1_en0", 1'b0, MODE_CLR, 1'b0, 1'b0, 1'b0, 1'b1);
    op1("w1_clr", 1'b1, MODE_CLR, 1'b1, 1'b1, 1'b1, 1'b0);
    op1("w1_load", 1'b1, MODE_LOAD, 1'b1, 1'b0, 1'b0, 1'b1);

    check_val("sb8_drained", 64'(sb8.size()), 64'd0);
    check_val("sb1_drained", 64'(sb1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/universal_register.md
Name: universal_register

Overview:
- Parametrised, edge-triggered storage register; the next generation of the single-bit D flip-flop.
- Provides WIDTH bits with enable and eight synchronous operating modes: hold, parallel load, shift left/right, rotate left/right, clear, invert.
- Has asynchronous active-high reset, complementary outputs and serial in/out taps, so instances can be chained into wider shift chains.
- Used as the general-purpose state element for counters, serial links and register banks in the storage library.

Parameters:
- WIDTH, 8, number of stored bits; legal range 1..64.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q while rst is high.

Ports:
- clk  input  1  clock; all state changes on rising edge except reset.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  operation enable; when 0 the register holds regardless of mode.
- mode  input  3  operation select, sampled on the rising clk edge (encoding below).
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial input entering bit 0 on shift left.
- sin_l  input  1  serial input entering bit WIDTH-1 on shift right.
- q  output  WIDTH  stored value.
- q_n  output  WIDTH  bitwise complement of q.
- sout_l  output  1  equals q[WIDTH-1]; chains to the next stage's sin_r.
- sout_r  output  1  equals q[0]; chains to the previous stage's sin_l.

Behaviour:
- Reset: rst=1 forces q=RESET_VAL immediately, without waiting for clk. Then q_n=~RESET_VAL, sout_l=RESET_VAL[WIDTH-1], sout_r=RESET_VAL[0].
- While rst=1, clock edges have no effect. The first active edge is the first rising clk after rst falls.
- Reset asserted mid-operation discards the in-flight operation. No partial update is visible.
- Latency: the result of an operation appears on q one clk edge after mode/en/d/sin are sampled. No combinational path exists from d to q.
- q_n, sout_l and sout_r are purely combinational from q and add no latency.
- en=0: q holds; mode, d and sin are ignored.
- en=1, mode encoding (next q):
  - 000 HOLD: q.
  - 001 LOAD: d.
  - 010 SHL: {q[WIDTH-2:0], sin_r}.
  - 011 SHR: {sin_l, q[WIDTH-1:1]}.
  - 100 ROL: {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: {q[0], q[WIDTH-1:1]}.
  - 110 CLR: all zeros. This is synchronous and distinct from RESET_VAL.
  - 111 INV: ~q (toggle every bit).
- WIDTH=1 boundary:
  - SHL yields sin_r; SHR yields sin_l.
  - ROL and ROR yield q (hold).
  - sout_l and sout_r both equal q[0].
- No X propagation from unused inputs: in modes other than LOAD, d must not affect q even if it is X. The same applies to sin_r and sin_l outside SHL/SHR.
- The register is fully synchronous apart from rst. There are no gated clocks and no latches.
- Simultaneous rst deassertion and clk edge is a recovery violation and is the integrator's responsibility. The bench deasserts rst away from clk edges.

Decomposition:
- Shared storage package:
  - mode constants MODE_HOLD=3'b000 through MODE_INV=3'b111;
  - the MODE_W=3 width constant.
- One natural sub-module: universal_register_cell, a single bit consisting of an 8:1 next-state mux plus an async-reset DFF.
  - Neighbour inputs: left, right, d, sin.
  - Reset-value bit as a parameter.
- The top level instantiates WIDTH cells via generate and wires edge cells to sin_r/sin_l or the wrap-around bits.

Test Plan:
- Async reset: RESET_VAL=8'hA5; pulse rst mid-cycle with no clk edge -> q=8'hA5 and q_n=8'h5A before the next edge; a LOAD in progress is discarded.
- Load/enable: en=1, LOAD, d=8'h3C -> q=8'h3C after 1 edge; en=0, LOAD, d=8'hFF for 3 edges -> q stays 8'h3C.
- Shifts:
  - q=8'h81, SHL, sin_r=1 -> 8'h03.
  - Then SHR, sin_l=0 -> 8'h01.
  - sout_r=1 and sout_l=0 are checked each cycle.
- Rotates: q=8'h81, ROL -> 8'h03; ROR twice from 8'h03 -> 8'h81 then 8'hC0; 8 ROLs from 8'h5A return to 8'h5A.
- Clear/invert/hold: q=8'h5A, INV -> 8'hA5, INV -> 8'h5A, CLR -> 8'h00 (not RESET_VAL 8'hA5), HOLD with d=X -> 8'h00 with no X on q.
- WIDTH=1 instance: SHL with sin_r=1 -> q=1; ROL holds 1; INV -> 0; sout_l=sout_r=q throughout.
